auc_ram_warb: RTL
=================

// Module: auc_ram_warb
// PURPOSE
//  Round-robin write-port arbiter for the ECC core operand RAM. Shares the
//  single RAM write port between NREQ requesters: req 0 host load, req 1
//  random-number unit (rand_wen/rand_wadd/rand_wdat), req 2 ECC ALU writeback.
//  Supports locked bursts so that a multi-word operand (e.g. scalar + blinding)
//  lands atomically. A lock timeout guards against a hung owner.
// PARAMETERS
//  WIDTH     256  RAM data width
//  ADDR      5    RAM address width
//  NREQ      3    number of requesters (>=2)
//  LOCK_TMO  16   idle cycles before a held lock is force-released; 0 = never
// PORTS
//  clk        in   1           clock, rising edge
//  rst        in   1           reset, asynchronous, active-low
//  req_wen    in   NREQ        per-requester write request (valid)
//  req_lock   in   NREQ        keep grant after this write (burst continues)
//  req_wadd   in   NREQ*ADDR   packed addresses; requester i at [i*ADDR +: ADDR]
//  req_wdat   in   NREQ*WIDTH  packed data; requester i at [i*WIDTH +: WIDTH]
//  gnt        out  NREQ        one-hot accept, combinational, same cycle
//  ram_wen    out  1           RAM write enable (registered)
//  ram_wadd   out  ADDR        RAM write address (registered)
//  ram_wdat   out  WIDTH       RAM write data (registered)
//  arb_lock   out  1           high while in LOCK state
//  lock_err   out  1           one-cycle pulse on lock timeout release
// BEHAVIOUR
//  - Reset (rst=0, async): ptr=0, state IDLE, owner=0, tmo_cnt=0, ram_wen=0,
//    ram_wadd=0, ram_wdat=0, lock_err=0. gnt=0 while rst=0.
//  - Handshake: transfer on rising edge where req_wen[i] & gnt[i]. Requester
//    holds req_wen/wadd/wdat/lock stable until gnt; one transfer per cycle max.
//  - Latency: ram_wen/wadd/wdat reflect the winning transfer exactly 1 cycle
//    after gnt; ram_wen=0 in any cycle following a cycle with no transfer.
//  - IDLE: gnt = first i with req_wen[i] searching ptr, ptr+1, ..., mod NREQ.
//    Transfer with req_lock[i]=0: ptr <= (i+1) mod NREQ, stay IDLE.
//    Transfer with req_lock[i]=1: owner <= i, tmo_cnt <= 0, go LOCK.
//  - LOCK: gnt = req_wen[owner] at bit owner only; others gnt=0.
//    Owner transfer, lock=1: stay, tmo_cnt <= 0.
//    Owner transfer, lock=0: ptr <= (owner+1) mod NREQ, go IDLE (last burst word).
//    No owner request: tmo_cnt++; when tmo_cnt reaches LOCK_TMO-1 (LOCK_TMO>0)
//    go IDLE next edge, ptr <= (owner+1) mod NREQ, lock_err pulses 1 cycle.
//    A request arriving on the timeout cycle is granted (no release that cycle).
//  - tmo_cnt width clog2(LOCK_TMO+1); saturates, never wraps.
//  - arb_lock = (state==LOCK), registered state, no combinational path to req.
//  - ram_wadd/ram_wdat hold last written value when ram_wen=0.
//  - No address decoding or range checks; writes forwarded as issued.
// TESTING
//  1 Single: req_wen=3'b010, wadd[1]=5'h03, wdat[1]=256'hA5 -> gnt=3'b010 same
//    cycle; next cycle ram_wen=1, ram_wadd=5'h03, ram_wdat=256'hA5.
//  2 Fairness: all three request every cycle from reset, lock=0 -> gnt sequence
//    001,010,100,001,...; ram_wen high every cycle after first.
//  3 Burst: req1 writes addrs 0..3, lock=1,1,1,0; req0 and req2 pending ->
//    only gnt[1] for 4 cycles, arb_lock high 3 cycles, then gnt 100 then 001.
//  4 Timeout (LOCK_TMO=8): req1 locks then drops req; req0 pending -> after 8
//    idle cycles lock_err=1 one cycle, arb_lock=0, gnt[0] next cycle.
//  5 Reset mid-burst: rst=0 while LOCK with owner 1 -> ram_wen, arb_lock,
//    gnt go 0 without clock; after release, req0|req2 -> gnt=3'b001 first.
//  6 Stability: assert (SVA) req_wen/wadd/wdat held until gnt; random traffic
//    10k cycles, scoreboard matches every accepted write to ram_* in order.

Source files
------------

// File: rtl/auc_ram_warb.sv
// Round-robin write-port arbiter for the ECC core operand RAM.
// Requesters may lock the port for multi-word bursts; a hung lock owner is released after LOCK_TMO idle cycles.
module auc_ram_warb #(
    parameter int WIDTH    = 256,
    parameter int ADDR     = 5,
    parameter int NREQ     = 3,
    parameter int LOCK_TMO = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_wen,
    input  logic [NREQ-1:0]         req_lock,
    input  logic [NREQ*ADDR-1:0]    req_wadd,
    input  logic [NREQ*WIDTH-1:0]   req_wdat,
    output logic [NREQ-1:0]         gnt,
    output logic                    ram_wen,
    output logic [ADDR-1:0]         ram_wadd,
    output logic [WIDTH-1:0]        ram_wdat,
    output logic                    arb_lock,
    output logic                    lock_err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = (LOCK_TMO > 0) ? $clog2(LOCK_TMO + 1) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    state_t             r_state, w_state_next;
    logic [PW-1:0]      r_ptr, w_ptr_next;
    logic [PW-1:0]      r_owner, w_owner_next;
    logic [TW-1:0]      r_tmo_cnt, w_tmo_cnt_next;
    logic               r_lock_err, w_lock_err_next;

    logic               r_ram_wen;
    logic [ADDR-1:0]    r_ram_wadd;
    logic [WIDTH-1:0]   r_ram_wdat;

    logic [ADDR-1:0]    w_wadd [NREQ];
    logic [WIDTH-1:0]   w_wdat [NREQ];
    logic [NREQ-1:0]    w_gnt_raw;
    logic [PW-1:0]      w_sel;
    logic [PW-1:0]      w_cand;
    logic [PW:0]        w_sum;
    logic               w_found;
    logic               w_xfer;

    function automatic logic [PW-1:0] f_next_idx(input logic [PW-1:0] idx);
        if (idx == PW'(NREQ - 1))
            return '0;
        else
            return idx + 1'b1;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign w_wadd[gi] = req_wadd[gi*ADDR +: ADDR];
            assign w_wdat[gi] = req_wdat[gi*WIDTH +: WIDTH];
            // Grants are forced low while reset is asserted, independent of the clock.
            assign gnt[gi]    = rst & w_gnt_raw[gi];
        end
    endgenerate

    assign w_xfer = |gnt;

    // Grant selection: locked owner only, otherwise first requester from r_ptr upward.
    always_comb begin
        w_gnt_raw = '0;
        w_sel     = '0;
        w_found   = 1'b0;
        w_sum     = '0;
        w_cand    = '0;
        if (r_state == S_LOCK) begin
            w_sel = r_owner;
            if (req_wen[r_owner]) begin
                w_gnt_raw[r_owner] = 1'b1;
            end
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                w_sum = {1'b0, r_ptr} + (PW+1)'(k);
                if (w_sum >= (PW+1)'(NREQ)) begin
                    w_sum = w_sum - (PW+1)'(NREQ);
                end
                w_cand = w_sum[PW-1:0];
                if (!w_found && req_wen[w_cand]) begin
                    w_found           = 1'b1;
                    w_sel             = w_cand;
                    w_gnt_raw[w_cand] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_ptr_next      = r_ptr;
        w_owner_next    = r_owner;
        w_tmo_cnt_next  = r_tmo_cnt;
        w_lock_err_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    if (req_lock[w_sel]) begin
                        w_state_next   = S_LOCK;
                        w_owner_next   = w_sel;
                        w_tmo_cnt_next = '0;
                    end else begin
                        w_ptr_next = f_next_idx(w_sel);
                    end
                end
            end
            S_LOCK: begin
                if (w_xfer) begin
                    if (req_lock[r_owner]) begin
                        w_tmo_cnt_next = '0;
                    end else begin
                        w_state_next = S_IDLE;
                        w_ptr_next   = f_next_idx(r_owner);
                    end
                end else if ((LOCK_TMO > 0) && (r_tmo_cnt == TW'(LOCK_TMO - 1))) begin
                    w_state_next    = S_IDLE;
                    w_ptr_next      = f_next_idx(r_owner);
                    w_lock_err_next = 1'b1;
                end else if (r_tmo_cnt != '1) begin
                    w_tmo_cnt_next = r_tmo_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_tmo_cnt  <= '0;
            r_lock_err <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ptr      <= w_ptr_next;
            r_owner    <= w_owner_next;
            r_tmo_cnt  <= w_tmo_cnt_next;
            r_lock_err <= w_lock_err_next;
        end
    end

    // Address and data hold their last written value between writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ram_wen  <= 1'b0;
            r_ram_wadd <= '0;
            r_ram_wdat <= '0;
        end else begin
            r_ram_wen <= w_xfer;
            if (w_xfer) begin
                r_ram_wadd <= w_wadd[w_sel];
                r_ram_wdat <= w_wdat[w_sel];
            end
        end
    end

    assign ram_wen  = r_ram_wen;
    assign ram_wadd = r_ram_wadd;
    assign ram_wdat = r_ram_wdat;
    assign arb_lock = (r_state == S_LOCK);
    assign lock_err = r_lock_err;

endmodule
